// File: rtl/sram_cache_controller_pkg.sv
// Shared constants for the read cache: address field positions, line width and FSM encoding.
package cache_pkg;
  localparam int SETS          = 64;
  localparam int IDX_W         = 6;
  localparam int TAG_W         = 10;
  localparam int LINE_W        = 64;
  localparam int WSEL_BIT      = 2;
  localparam int INDEX_LSB     = 3;
  localparam int INDEX_MSB     = 8;
  localparam int TAG_LSB       = 9;
  localparam int TAG_MSB       = 18;
  localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_GAP   = 3'd2,
    S_RD_HI = 3'd3,
    S_FILL  = 3'd4,
    S_WR    = 3'd5
  } state_e;
endpackage

// File: rtl/sram_cache_controller_mem.sv
// Storage for the 2-way cache: per-set valid/tag/data/lru with async set read and sync updates.
module cache_mem
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [1:0]        valid_o,
  output logic [TAG_W-1:0]  tag0_o,
  output logic [TAG_W-1:0]  tag1_o,
  output logic [LINE_W-1:0] data0_o,
  output logic [LINE_W-1:0] data1_o,
  output logic              lru_o,
  input  logic              fill_en_i,
  input  logic              fill_way_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_data_i,
  input  logic              lru_we_i,
  input  logic              lru_i,
  input  logic              inv_en_i,
  input  logic              inv_way_i
);
  logic [1:0]        valid_q [SETS];
  logic              lru_q   [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][2];
  logic [LINE_W-1:0] data_q  [SETS][2];

  assign valid_o = valid_q[idx_i];
  assign lru_o   = lru_q[idx_i];
  assign tag0_o  = tag_q[idx_i][0];
  assign tag1_o  = tag_q[idx_i][1];
  assign data0_o = data_q[idx_i][0];
  assign data1_o = data_q[idx_i][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 2'b00;
        lru_q[s]   <= 1'b0;
      end
    end else begin
      if (fill_en_i) valid_q[idx_i][fill_way_i] <= 1'b1;
      if (inv_en_i)  valid_q[idx_i][inv_way_i]  <= 1'b0;
      if (lru_we_i)  lru_q[idx_i]               <= lru_i;
    end
  end

  // Tag and data need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[idx_i][fill_way_i]  <= fill_tag_i;
      data_q[idx_i][fill_way_i] <= fill_data_i;
    end
  end
endmodule

// File: rtl/sram_cache_controller.sv
// Write-through, no-write-allocate 2-way read cache between the MEM stage and the SRAM controller.
module sram_cache_controller
  import cache_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_read_en,
  output logic        sram_write_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready,
  output logic [2:0]  dbg_state_o
);
  state_e             state_q;
  logic [31:0]        word0_q, word1_q;
  logic [31:0]        a;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag, tag0, tag1;
  logic               wsel, hit0, hit1, hit, hit_way, victim, lru;
  logic [1:0]         valid;
  logic [LINE_W-1:0]  data0, data1, hit_line;
  logic [31:0]        hit_word;
  logic               fill_en, lru_we, lru_val, inv_en;
  logic               unused_addr_bits;

  assign a    = address - ADDR_BASE;
  assign idx  = a[INDEX_MSB:INDEX_LSB];
  assign tag  = a[TAG_MSB:TAG_LSB];
  assign wsel = a[WSEL_BIT];
  assign unused_addr_bits = ^{a[31:TAG_MSB+1], a[1:0]};

  cache_mem u_mem (
    .clk         (clk),
    .rst         (rst),
    .idx_i       (idx),
    .valid_o     (valid),
    .tag0_o      (tag0),
    .tag1_o      (tag1),
    .data0_o     (data0),
    .data1_o     (data1),
    .lru_o       (lru),
    .fill_en_i   (fill_en),
    .fill_way_i  (victim),
    .fill_tag_i  (tag),
    .fill_data_i ({word1_q, word0_q}),
    .lru_we_i    (lru_we),
    .lru_i       (lru_val),
    .inv_en_i    (inv_en),
    .inv_way_i   (hit_way)
  );

  assign hit0     = valid[0] && (tag0 == tag);
  assign hit1     = valid[1] && (tag1 == tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1;
  assign hit_line = hit1 ? data1 : data0;
  assign hit_word = wsel ? hit_line[63:32] : hit_line[31:0];
  // Fill the first empty way before consulting lru.
  assign victim   = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru);

  assign sram_wdata  = wdata;
  assign dbg_state_o = state_q;

  always_comb begin
    ready         = 1'b1;
    rdata         = 32'h0;
    sram_read_en  = 1'b0;
    sram_write_en = 1'b0;
    sram_address  = 32'h0;
    fill_en       = 1'b0;
    lru_we        = 1'b0;
    lru_val       = 1'b0;
    inv_en        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read_en) begin
          if (hit) begin
            rdata   = hit_word;
            lru_we  = 1'b1;
            lru_val = ~hit_way;
          end else begin
            ready = 1'b0;
          end
        end else if (write_en) begin
          ready  = 1'b0;
          inv_en = hit;
        end
      end
      S_RD_LO: begin
        ready        = 1'b0;
        sram_read_en = 1'b1;
        sram_address = {address[31:3], 3'b000};
      end
      S_GAP: ready = 1'b0;
      S_RD_HI: begin
        ready        = 1'b0;
        sram_read_en = 1'b1;
        sram_address = {address[31:3], 3'b100};
      end
      S_FILL: begin
        fill_en = 1'b1;
        lru_we  = 1'b1;
        lru_val = ~victim;
        rdata   = wsel ? word1_q : word0_q;
      end
      S_WR: begin
        sram_write_en = 1'b1;
        sram_address  = address;
        ready         = sram_ready;
      end
      default: ready = 1'b1;
    endcase
    // While reset is held the pipeline must see an idle, ready cache.
    if (rst) begin
      ready         = 1'b1;
      rdata         = 32'h0;
      sram_read_en  = 1'b0;
      sram_write_en = 1'b0;
      fill_en       = 1'b0;
      lru_we        = 1'b0;
      inv_en        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      word0_q <= 32'h0;
      word1_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (read_en) begin
            if (!hit) state_q <= S_RD_LO;
          end else if (write_en) begin
            state_q <= S_WR;
          end
        end
        S_RD_LO: if (sram_ready) begin
          word0_q <= sram_rdata;
          state_q <= S_GAP;
        end
        S_GAP: state_q <= S_RD_HI;
        S_RD_HI: if (sram_ready) begin
          word1_q <= sram_rdata;
          state_q <= S_FILL;
        end
        S_FILL: state_q <= S_IDLE;
        S_WR: if (sram_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_cache_controller.sv
// Bench for sram_cache_controller: table of requests plus a reset-during-miss sequence.
module tb_sram_cache_controller;
  import cache_pkg::*;

  localparam int MISS_CYC = 17;
  localparam int HIT_CYC  = 1;
  localparam int WR_CYC   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_en, write_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic        sram_read_en, sram_write_en;
  logic [31:0] sram_address, sram_wdata, sram_rdata;
  logic        sram_ready;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int cnt;

  logic [31:0] exp_q[$];
  logic [31:0] sram_exp_q[$];
  logic [31:0] wd_exp_q[$];

  logic [31:0] wr_mem [4096];
  bit          wr_vld [4096];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    int          exp_cyc;
    logic        exp_fetch;
    logic        exp_store;
  } vec_t;

  vec_t vecs[16];

  sram_cache_controller dut (
    .clk           (clk),
    .rst           (rst),
    .read_en       (read_en),
    .write_en      (write_en),
    .address       (address),
    .wdata         (wdata),
    .rdata         (rdata),
    .ready         (ready),
    .sram_read_en  (sram_read_en),
    .sram_write_en (sram_write_en),
    .sram_address  (sram_address),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata),
    .sram_ready    (sram_ready),
    .dbg_state_o   (dbg_state)
  );

  always #5 clk = ~clk;

  // SRAM controller model: ready after 6 cycles of enable.
  function automatic logic [31:0] base_data(input logic [31:0] ad);
    case (ad)
      32'h400:  return 32'hAAAA0001;
      32'h404:  return 32'hBBBB0002;
      32'h800:  return 32'hCCCC0003;
      32'h804:  return 32'hEEEE0005;
      32'hC00:  return 32'hDDDD0004;
      32'h2008: return 32'h2008C0DE;
      32'h200C: return 32'h200CBEEF;
      default:  return {16'hD000, ad[15:0]};
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if ((sram_read_en || sram_write_en) && !sram_ready) cnt <= cnt + 1;
    else cnt <= 0;
  end

  assign sram_ready = (sram_read_en || sram_write_en) && (cnt == 6);
  assign sram_rdata = !sram_read_en ? 32'h0 :
                      (wr_vld[sram_address[13:2]] ? wr_mem[sram_address[13:2]]
                                                  : base_data(sram_address));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard for the SRAM side: every completed op is matched against the expected address queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (sram_read_en && sram_write_en) overlap <= overlap + 1;
      if (sram_ready) begin
        if (sram_exp_q.size() == 0) begin
          check("sram_unexpected_op", sram_address, 32'hFFFFFFFF);
        end else begin
          check("sram_addr", sram_address, sram_exp_q.pop_front());
          if (sram_write_en) begin
            if (wd_exp_q.size() == 0) check("sram_unexpected_wr", sram_wdata, 32'hFFFFFFFF);
            else check("sram_wdata", sram_wdata, wd_exp_q.pop_front());
            wr_mem[sram_address[13:2]] <= sram_wdata;
            wr_vld[sram_address[13:2]] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic do_req(input vec_t v, input string name);
    int cyc;
    if (v.exp_fetch) begin
      sram_exp_q.push_back({v.addr[31:3], 3'b000});
      sram_exp_q.push_back({v.addr[31:3], 3'b100});
    end
    if (v.exp_store) begin
      sram_exp_q.push_back(v.addr);
      wd_exp_q.push_back(v.wd);
    end
    if (v.rd) exp_q.push_back(v.exp_rdata);
    read_en  = v.rd;
    write_en = v.wr;
    address  = v.addr;
    wdata    = v.wd;
    cyc = 1;
    #1;
    while (!ready && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check({name, "_cycles"}, cyc, v.exp_cyc);
    if (v.rd) check({name, "_rdata"}, rdata, exp_q.pop_front());
    @(negedge clk);
    read_en  = 1'b0;
    write_en = 1'b0;
    check({name, "_ops_left"}, sram_exp_q.size(), 0);
  endtask

  initial begin
    int guard;
    vecs[0]  = '{1'b1, 1'b0, 32'h400,  32'h0,        32'hAAAA0001, MISS_CYC, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h404,  32'h0,        32'hBBBB0002, HIT_CYC,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h800,  32'h0,        32'hCCCC0003, MISS_CYC, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'hC00,  32'h0,        32'hDDDD0004, MISS_CYC, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h800,  32'h0,        32'hCCCC0003, HIT_CYC,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h400,  32'h0,        32'hAAAA0001, MISS_CYC, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h800,  32'h0,        32'hCCCC0003, HIT_CYC,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h400,  32'h0,        32'hAAAA0001, HIT_CYC,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h400,  32'h12345678, 32'h0,        WR_CYC,   1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'h400,  32'h0,        32'h12345678, MISS_CYC, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, 32'h0,        WR_CYC,   1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h804,  32'h0,        32'hEEEE0005, HIT_CYC,  1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h404,  32'h0,        32'hBBBB0002, HIT_CYC,  1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h1000, 32'h0,        32'hCAFEF00D, MISS_CYC, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 32'h2008, 32'h55555555, 32'h2008C0DE, MISS_CYC, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 32'h200C, 32'h0,        32'h200CBEEF, HIT_CYC,  1'b0, 1'b0};

    rst = 1'b1;
    read_en = 1'b0;
    write_en = 1'b0;
    address = 32'h0;
    wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_rdata", rdata, 0);
    check("rst_rd_en", sram_read_en, 0);
    check("rst_wr_en", sram_write_en, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_state", dbg_state, S_IDLE);
    check("idle_ready", ready, 1);

    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while the second half of a line fetch is outstanding.
    sram_exp_q.push_back(32'h3010);
    sram_exp_q.push_back(32'h3014);
    read_en = 1'b1;
    address = 32'h3010;
    guard = 0;
    while (dbg_state != S_RD_HI && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reach_rd_hi", dbg_state, S_RD_HI);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_rd_en", sram_read_en, 0);
    check("midrst_wr_en", sram_write_en, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_state", dbg_state, S_IDLE);
    read_en = 1'b0;
    sram_exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req('{1'b1, 1'b0, 32'h2008, 32'h0, 32'h2008C0DE, MISS_CYC, 1'b1, 1'b0}, "post_rst");

    repeat (2) @(negedge clk);
    check("enable_overlap", overlap, 0);
    check("rdata_queue_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
